// File: rtl/chebyshev_pkg.sv
// Shared definitions for the Chebyshev evaluator: FSM encoding, default number
// format and the word-length saturation used by this stage and the adder stage.
package chebyshev_pkg;

    localparam int WL_DEF   = 16;
    localparam int FRAC_DEF = 14;
    localparam int SAT_W    = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        MUL  = 2'd2,
        SUB  = 2'd3
    } cheb_state_e;

    // Clamp v to the signed range of a wl-bit word; the result stays SAT_W wide.
    function automatic logic signed [SAT_W-1:0] sat_wl(input logic signed [SAT_W-1:0] v,
                                                      input int wl);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = $signed((64'd1 << (wl - 32'sd1)) - 64'd1);
        min_v = -max_v - 64'sd1;
        if (v > max_v) begin
            sat_wl = max_v;
        end else if (v < min_v) begin
            sat_wl = min_v;
        end else begin
            sat_wl = v;
        end
    endfunction

    function automatic logic sat_wl_hit(input logic signed [SAT_W-1:0] v,
                                        input int wl);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = $signed((64'd1 << (wl - 32'sd1)) - 64'd1);
        min_v = -max_v - 64'sd1;
        sat_wl_hit = (v > max_v) || (v < min_v);
    endfunction

endpackage

// File: rtl/cheb_fx_mult.sv
// Registered signed WL x WL -> 2*WL multiplier with one cycle of latency.
module cheb_fx_mult
#(
    parameter int WL = 16
)(
    input  logic            clock,
    input  logic            resetn,
    input  logic            en,
    input  logic [WL-1:0]   a,
    input  logic [WL-1:0]   b,
    output logic [2*WL-1:0] p
);

    logic signed [2*WL-1:0] p_r;

    // Product register, loaded only while the controller is in its multiply step.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            p_r <= {(2*WL){1'b0}};
        end else if (en) begin
            p_r <= $signed(a) * $signed(b);
        end else begin
            p_r <= p_r;
        end
    end

    assign p = p_r;

endmodule

// File: rtl/chebyshev_term_gen.sv
// Streams T_0(x)..T_n(x) using T_{k+1} = 2x*T_k - T_{k-1}, one term per
// valid/ready beat, with saturation to WL bits feeding back into the recurrence.
module chebyshev_term_gen
    import chebyshev_pkg::*;
#(
    parameter int WL    = WL_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int N_MAX = 12,
    parameter int CW    = 4
)(
    input  logic          clock,
    input  logic          resetn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WL-1:0] in_x,
    input  logic [CW-1:0] in_order,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WL-1:0] out_t,
    output logic [CW-1:0] out_k,
    output logic          out_last,
    output logic          out_sat
);

    localparam logic signed [WL-1:0] T0_VAL  = {{(WL-1){1'b0}}, 1'b1} << FRAC;
    localparam logic [CW-1:0]        N_MAX_C = CW'(N_MAX);
    localparam logic [CW-1:0]        K_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]        K_ZERO  = {CW{1'b0}};

    cheb_state_e            state_r;
    logic signed [WL-1:0]   x_r;
    logic signed [WL-1:0]   t_cur_r;
    logic signed [WL-1:0]   t_prev_r;
    logic [CW-1:0]          k_r;
    logic [CW-1:0]          n_eff_r;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic signed [WL-1:0]   out_t_r;
    logic [CW-1:0]          out_k_r;
    logic                   out_last_r;
    logic                   out_sat_r;

    logic [CW-1:0]          n_req_s;
    logic [CW-1:0]          k_inc_s;
    logic                   mul_en_s;
    logic signed [2*WL-1:0] prod_s;
    logic signed [2*WL-1:0] prod_shift_s;
    logic signed [2*WL:0]   diff_s;
    logic signed [SAT_W-1:0] diff_ext_s;
    logic signed [WL-1:0]   t_next_s;
    logic                   t_next_sat_s;

    // Requested order clamped to the highest supported term.
    always_comb begin
        n_req_s = in_order;
        if (in_order > N_MAX_C) begin
            n_req_s = N_MAX_C;
        end else begin
            n_req_s = in_order;
        end
    end

    // Next term: 2x*T_k is the product scaled by FRAC-1, minus T_{k-1}, at 2*WL+1 bits.
    always_comb begin
        prod_shift_s = prod_s >>> (FRAC - 1);
        diff_s       = $signed({prod_shift_s[2*WL-1], prod_shift_s})
                     - $signed({{(WL+1){t_prev_r[WL-1]}}, t_prev_r});
        diff_ext_s   = $signed({{(SAT_W-2*WL-1){diff_s[2*WL]}}, diff_s});
        t_next_s     = WL'(sat_wl(diff_ext_s, WL));
        t_next_sat_s = sat_wl_hit(diff_ext_s, WL);
    end

    assign k_inc_s  = k_r + K_ONE;
    assign mul_en_s = (state_r == MUL);

    cheb_fx_mult #(
        .WL (WL)
    ) u_mult (
        .clock  (clock),
        .resetn (resetn),
        .en     (mul_en_s),
        .a      (x_r),
        .b      (t_cur_r),
        .p      (prod_s)
    );

    // Sequencer: accept, present each term until taken, then multiply and subtract.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r     <= IDLE;
            x_r         <= {WL{1'b0}};
            t_cur_r     <= {WL{1'b0}};
            t_prev_r    <= {WL{1'b0}};
            k_r         <= K_ZERO;
            n_eff_r     <= K_ZERO;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_t_r     <= {WL{1'b0}};
            out_k_r     <= K_ZERO;
            out_last_r  <= 1'b0;
            out_sat_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        x_r         <= $signed(in_x);
                        n_eff_r     <= n_req_s;
                        t_cur_r     <= T0_VAL;
                        t_prev_r    <= {WL{1'b0}};
                        k_r         <= K_ZERO;
                        out_valid_r <= 1'b1;
                        out_t_r     <= T0_VAL;
                        out_k_r     <= K_ZERO;
                        out_last_r  <= (n_req_s == K_ZERO);
                        out_sat_r   <= 1'b0;
                        in_ready_r  <= 1'b0;
                        state_r     <= EMIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (k_r == n_eff_r) begin
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            in_ready_r  <= 1'b1;
                            state_r     <= IDLE;
                        end else if (k_r == K_ZERO) begin
                            // T_1 is x itself, so it skips the multiply.
                            t_prev_r    <= t_cur_r;
                            t_cur_r     <= x_r;
                            k_r         <= K_ONE;
                            out_valid_r <= 1'b1;
                            out_t_r     <= x_r;
                            out_k_r     <= K_ONE;
                            out_last_r  <= (n_eff_r == K_ONE);
                            out_sat_r   <= 1'b0;
                            state_r     <= EMIT;
                        end else begin
                            out_valid_r <= 1'b0;
                            state_r     <= MUL;
                        end
                    end else begin
                        state_r <= EMIT;
                    end
                end
                MUL: begin
                    state_r <= SUB;
                end
                SUB: begin
                    t_prev_r    <= t_cur_r;
                    t_cur_r     <= t_next_s;
                    k_r         <= k_inc_s;
                    out_valid_r <= 1'b1;
                    out_t_r     <= t_next_s;
                    out_k_r     <= k_inc_s;
                    out_last_r  <= (k_inc_s == n_eff_r);
                    out_sat_r   <= t_next_sat_s;
                    state_r     <= EMIT;
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_t     = out_t_r;
    assign out_k     = out_k_r;
    assign out_last  = out_last_r;
    assign out_sat   = out_sat_r;

endmodule

// File: tb/tb_chebyshev_term_gen.sv
// Directed and randomized checks of chebyshev_term_gen against an arithmetic
// model of the Chebyshev recurrence with WL-bit saturation.
module tb_chebyshev_term_gen;

    logic        clock = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [3:0]  in_order;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_t;
    logic [3:0]  out_k;
    logic        out_last;
    logic        out_sat;

    int checks   = 0;
    int failures = 0;

    chebyshev_term_gen dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_order  (in_order),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_t     (out_t),
        .out_k     (out_k),
        .out_last  (out_last),
        .out_sat   (out_sat)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One request; stall_k selects a beat held under backpressure for 5 cycles.
    task automatic do_req(input logic signed [15:0] x, input logic [3:0] ord,
                          input int stall_k, input bit pulse_busy);
        longint exp_t [0:12];
        bit     exp_s [0:12];
        longint xl;
        longint v;
        int     n_eff;
        int     beat;
        int     cyc;
        int     prev_cyc;
        xl    = x;
        n_eff = (ord > 4'd12) ? 12 : int'(ord);
        exp_t[0] = 16384;
        exp_s[0] = 1'b0;
        exp_t[1] = xl;
        exp_s[1] = 1'b0;
        for (int k = 2; k <= n_eff; k++) begin
            v = ((xl * exp_t[k-1]) >>> 13) - exp_t[k-2];
            exp_s[k] = (v > 32767) || (v < -32768);
            if (v > 32767) v = 32767;
            else if (v < -32768) v = -32768;
            exp_t[k] = v;
        end

        chk("idle_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_x     = x;
        in_order = ord;
        @(posedge clock); #1;
        in_valid = 1'b0;
        beat     = 0;
        cyc      = 0;
        prev_cyc = 0;
        while (beat <= n_eff && cyc < 200) begin
            if (out_valid) begin
                chk("beat_k", out_k, beat);
                chk("beat_t", $signed(out_t), exp_t[beat]);
                chk("beat_last", out_last, (beat == n_eff));
                chk("beat_sat", out_sat, exp_s[beat]);
                chk("beat_gap", cyc - prev_cyc, (beat == 0) ? 0 : ((beat == 1) ? 1 : 3));
                if (beat == stall_k) begin
                    out_ready = 1'b0;
                    for (int s = 0; s < 5; s++) begin
                        in_valid = pulse_busy && (s == 1);
                        in_x     = 16'h1234;
                        in_order = 4'd1;
                        @(posedge clock); #1;
                        cyc++;
                        chk("stall_valid", out_valid, 1);
                        chk("stall_t", $signed(out_t), exp_t[beat]);
                        chk("stall_k", out_k, beat);
                        chk("stall_last", out_last, (beat == n_eff));
                        chk("stall_sat", out_sat, exp_s[beat]);
                        chk("stall_busy", in_ready, 0);
                    end
                    in_valid  = 1'b0;
                    out_ready = 1'b1;
                end
                prev_cyc = cyc;
                beat++;
            end
            @(posedge clock); #1;
            cyc++;
        end
        chk("seq_complete", (beat > n_eff), 1);
        chk("done_in_ready", in_ready, 1);
        chk("done_valid", out_valid, 0);
    endtask

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_x      = 16'h0000;
        in_order  = 4'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_t", out_t, 0);
        chk("rst_k", out_k, 0);
        chk("rst_last", out_last, 0);
        chk("rst_sat", out_sat, 0);
        chk("rst_in_ready", in_ready, 1);
        resetn = 1'b1;

        do_req(16'sd8192, 4'd3, -1, 1'b0);
        do_req(16'sd16384, 4'd5, -1, 1'b0);
        do_req(-16'sd16384, 4'd4, -1, 1'b0);
        do_req(16'sd31130, 4'd2, -1, 1'b0);
        do_req(16'sd0, 4'd2, -1, 1'b0);
        do_req(16'sd5000, 4'd0, -1, 1'b0);
        do_req(-16'sd12000, 4'd15, -1, 1'b0);
        do_req(16'sd12000, 4'd5, 2, 1'b1);

        // Reset while the multiplier step of an order-6 request is in flight.
        in_valid = 1'b1;
        in_x     = 16'sd9000;
        in_order = 4'd6;
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("mid_t0_valid", out_valid, 1);
        @(posedge clock); #1;
        chk("mid_t1_k", out_k, 1);
        @(posedge clock); #1;
        chk("mid_mul_valid", out_valid, 0);
        resetn = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_last", out_last, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            chk("mid_rst_quiet", out_valid, 0);
        end
        do_req(16'sd8192, 4'd3, -1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            logic [15:0] rx;
            logic [3:0]  ro;
            rx = 16'($urandom_range(0, 65535));
            ro = 4'($urandom_range(0, 15));
            do_req($signed(rx), ro, (r % 2 == 0) ? int'($urandom_range(0, 4)) : -1, r[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
